// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the single synchronous memory port among fetch (0),
// execute (1) and host/loader (2) using a registered one-hot grant, round-robin
// selection and a per-owner hold limit so no requester starves fetch.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req_i[2:0]          per-requester access request (level)
//   we_i[2:0]           per-requester write enable, qualified by req_i
//   addr_i / wdata_i    per-requester address / write data, requester k at
//                       [k*W +: W]
//   gnt_o[2:0]          registered one-hot grant (or 000)
//   rvalid_o[2:0]       read-data-valid pulse, one cycle after a read beat
//   rdata_o             shared read data, valid where rvalid_o is set
//   mem_addr_o, mem_data_out_o, mem_we_o   memory request, driven only in a beat
//   mem_data_in_i       memory read data, valid one cycle after the address
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req_i,
  input  logic [2:0]            we_i,
  input  logic [3*ADDR_W-1:0]   addr_i,
  input  logic [3*DATA_W-1:0]   wdata_i,
  output logic [2:0]            gnt_o,
  output logic [2:0]            rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_data_out_o,
  output logic                  mem_we_o,
  input  logic [DATA_W-1:0]     mem_data_in_i
);

  localparam int unsigned NREQ   = 3;
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [2:0]          gnt_q, gnt_d;
  logic [1:0]          last_q, last_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                rd_pend_q, rd_pend_d;
  logic [1:0]          rd_id_q, rd_id_d;

  logic [1:0]          ptr, cand1, cand2, win;
  logic                win_found;
  logic                beat_c;
  logic                others_wait;
  logic                hold_limit;
  logic [HOLD_W:0]     hold_next;
  logic                take_win;

  // Modulo-3 increment of a requester index.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    inc3 = (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] k);
    onehot = 3'b001 << k;
  endfunction

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    ptr       = inc3(last_q);
    cand1     = inc3(ptr);
    cand2     = inc3(cand1);
    win_found = 1'b1;
    win       = ptr;
    if (req_i[ptr])        win = ptr;
    else if (req_i[cand1]) win = cand1;
    else if (req_i[cand2]) win = cand2;
    else                   win_found = 1'b0;
  end

  assign beat_c      = (state_q == S_OWN) && req_i[owner_q];
  assign others_wait = |(req_i & ~onehot(owner_q));
  assign hold_next   = {1'b0, hold_q} + (HOLD_W+1)'(1);
  // Compared with >= so a saturated counter still yields to a late waiter.
  assign hold_limit  = hold_next >= (HOLD_W+1)'(MAX_HOLD);

  // Next-state: grant movement, hold counting and read tracking.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    hold_d    = hold_q;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    take_win  = 1'b0;

    case (state_q)
      S_IDLE: begin
        take_win = win_found;
      end
      S_OWN: begin
        if (!req_i[owner_q]) begin
          // Release: owner has req low, so the search cannot pick it.
          take_win = win_found;
          if (!win_found) state_d = S_IDLE;
        end else begin
          rd_pend_d = ~we_i[owner_q];
          rd_id_d   = owner_q;
          if (hold_limit && others_wait) begin
            take_win = 1'b1;
          end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (take_win) begin
      state_d = S_OWN;
      owner_d = win;
      last_d  = win;
      hold_d  = '0;
    end

    gnt_d = (state_d == S_OWN) ? onehot(owner_d) : 3'b000;
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      owner_q   <= 2'd0;
      gnt_q     <= 3'b000;
      last_q    <= 2'd2;
      hold_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  // Memory request mux: the owner's fields only during a beat, else zero.
  always_comb begin
    mem_addr_o     = '0;
    mem_data_out_o = '0;
    mem_we_o       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (beat_c && owner_q == 2'(k)) begin
        mem_addr_o     = addr_i[k*ADDR_W +: ADDR_W];
        mem_data_out_o = wdata_i[k*DATA_W +: DATA_W];
        mem_we_o       = we_i[k];
      end
    end
  end

  assign gnt_o    = gnt_q;
  assign rvalid_o = rd_pend_q ? onehot(rd_id_q) : 3'b000;
  assign rdata_o  = rd_pend_q ? mem_data_in_i : '0;

endmodule
